// File: rtl/controller_poll_scheduler.sv
// rtl/controller_poll_scheduler.sv - gamepad poll sequencer with edge masks, CPU registers and capture IRQ
module controller_poll_scheduler #(
    parameter int NUM_CONTROLLERS = 2,
    parameter int SETTLE_CYCLES   = 16,
    parameter int POLL_DIVIDER    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic                         poll_req,
    output logic                         start_fetch,
    input  logic [8*NUM_CONTROLLERS-1:0] buttons_in,
    input  logic                         cpu_rd,
    input  logic [3:0]                   cpu_addr,
    output logic [7:0]                   cpu_rdata,
    output logic                         busy,
    output logic                         irq,
    input  logic                         irq_ack
);

    localparam int         SW         = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0] DIV_LAST   = 8'(POLL_DIVIDER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   settle_q;
    logic [7:0]      div_q;
    logic            pending_q;
    logic            overrun_q;
    logic [5:0]      capture_count_q;

    logic [7:0]      cur_q      [NUM_CONTROLLERS];
    logic [7:0]      pressed_q  [NUM_CONTROLLERS];
    logic [7:0]      released_q [NUM_CONTROLLERS];

    logic            div_trig;
    logic            trigger;
    logic            capture;
    logic            overrun_set;

    logic [1:0]      rd_ctrl;
    logic [1:0]      rd_reg;
    logic            clr_overrun;
    logic [NUM_CONTROLLERS-1:0] clr_pressed;
    logic [NUM_CONTROLLERS-1:0] clr_released;
    logic [7:0]      status_byte;
    logic [7:0]      rd_mux;

    assign div_trig    = frame_tick && (div_q == DIV_LAST);
    assign trigger     = div_trig || poll_req;
    assign capture     = (state_q == S_CAPTURE);
    // A third trigger while one is already queued behind an active poll is lost.
    assign overrun_set = trigger && (state_q != S_IDLE) && pending_q;

    assign rd_ctrl     = cpu_addr[3:2];
    assign rd_reg      = cpu_addr[1:0];
    assign clr_overrun = cpu_rd && (rd_reg == 2'd3);
    assign status_byte = {capture_count_q, overrun_q, busy};

    // Frame divider: count frame ticks, wrap and fire on the last one of each group.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 8'd0;
        end else if (frame_tick) begin
            div_q <= div_trig ? 8'd0 : div_q + 8'd1;
        end
    end

    // Register read mux and clear-on-read decode for the addressed controller.
    always_comb begin
        rd_mux       = 8'h00;
        clr_pressed  = '0;
        clr_released = '0;
        for (int k = 0; k < NUM_CONTROLLERS; k++) begin
            if (rd_ctrl == 2'(k)) begin
                clr_pressed[k]  = cpu_rd && (rd_reg == 2'd1);
                clr_released[k] = cpu_rd && (rd_reg == 2'd2);
                case (rd_reg)
                    2'd0:    rd_mux = cur_q[k];
                    2'd1:    rd_mux = pressed_q[k];
                    2'd2:    rd_mux = released_q[k];
                    default: rd_mux = 8'h00;
                endcase
            end
        end
        if (rd_reg == 2'd3) begin
            rd_mux = status_byte;
        end
    end

    // Poll sequencer: trigger queueing, fetch strobe, settle wait, capture bookkeeping, irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            settle_q        <= '0;
            start_fetch     <= 1'b0;
            busy            <= 1'b0;
            irq             <= 1'b0;
            pending_q       <= 1'b0;
            overrun_q       <= 1'b0;
            capture_count_q <= 6'd0;
        end else begin
            start_fetch <= 1'b0;
            // Clear first, then OR in a same-cycle set so a fresh event is never lost.
            overrun_q   <= (overrun_q && !clr_overrun) || overrun_set;
            // A capture in the same cycle as an acknowledge keeps the interrupt raised.
            irq         <= capture || (irq && !irq_ack);

            if (state_q != S_IDLE && trigger) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (trigger || pending_q) begin
                        state_q     <= S_FETCH;
                        start_fetch <= 1'b1;
                        busy        <= 1'b1;
                        // Consuming a queued poll while a new trigger arrives re-queues it.
                        pending_q   <= pending_q && trigger;
                    end
                end
                S_FETCH: begin
                    settle_q <= SETTLE_LOAD;
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state_q         <= S_IDLE;
                    busy            <= 1'b0;
                    capture_count_q <= capture_count_q + 6'd1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Button snapshot and sticky edge masks, cleared on read before new edges are merged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) begin
                cur_q[k]      <= 8'h00;
                pressed_q[k]  <= 8'h00;
                released_q[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) begin
                pressed_q[k]  <= (clr_pressed[k] ? 8'h00 : pressed_q[k])
                               | (capture ? (buttons_in[8*k +: 8] & ~cur_q[k]) : 8'h00);
                released_q[k] <= (clr_released[k] ? 8'h00 : released_q[k])
                               | (capture ? (~buttons_in[8*k +: 8] & cur_q[k]) : 8'h00);
                if (capture) begin
                    cur_q[k] <= buttons_in[8*k +: 8];
                end
            end
        end
    end

    // Registered CPU read data; holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata <= 8'h00;
        end else if (cpu_rd) begin
            cpu_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_controller_poll_scheduler.sv
// tb/tb_controller_poll_scheduler.sv - scoreboard bench for controller_poll_scheduler
module tb_controller_poll_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        frame_tick2;
    logic        poll_req;
    logic        start_fetch;
    logic [15:0] buttons;
    logic        cpu_rd;
    logic [3:0]  cpu_addr;
    logic [7:0]  cpu_rdata;
    logic        busy;
    logic        irq;
    logic        irq_ack;

    logic        start_fetch2;
    logic [7:0]  cpu_rdata2;
    logic        busy2;
    logic        irq2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int exp_sf[$];
    int exp_sf2[$];
    int exp_irq[$];
    int exp_rd[$];

    logic rd_seen  = 1'b0;
    logic irq_prev = 1'b0;

    controller_poll_scheduler #(
        .NUM_CONTROLLERS(2),
        .SETTLE_CYCLES  (16),
        .POLL_DIVIDER   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .poll_req   (poll_req),
        .start_fetch(start_fetch),
        .buttons_in (buttons),
        .cpu_rd     (cpu_rd),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .busy       (busy),
        .irq        (irq),
        .irq_ack    (irq_ack)
    );

    controller_poll_scheduler #(
        .NUM_CONTROLLERS(2),
        .SETTLE_CYCLES  (16),
        .POLL_DIVIDER   (3)
    ) dut_div3 (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick2),
        .poll_req   (1'b0),
        .start_fetch(start_fetch2),
        .buttons_in (buttons),
        .cpu_rd     (1'b0),
        .cpu_addr   (4'd0),
        .cpu_rdata  (cpu_rdata2),
        .busy       (busy2),
        .irq        (irq2),
        .irq_ack    (1'b0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= cpu_rd;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected events whenever the DUT presents a strobe, irq edge or read data.
    always @(negedge clk) begin
        if (start_fetch) begin
            if (exp_sf.size() == 0) check("sf_unexpected", cyc, -1);
            else check("sf_cycle", cyc, exp_sf.pop_front());
        end
        if (start_fetch2) begin
            if (exp_sf2.size() == 0) check("sf2_unexpected", cyc, -1);
            else check("sf2_cycle", cyc, exp_sf2.pop_front());
        end
        if (irq && !irq_prev) begin
            if (exp_irq.size() == 0) check("irq_unexpected", cyc, -1);
            else check("irq_rise_cycle", cyc, exp_irq.pop_front());
        end
        irq_prev = irq;
        if (rd_seen && !rst) begin
            if (exp_rd.size() == 0) check("rd_unexpected", int'(cpu_rdata), -1);
            else check("rd_data", int'(cpu_rdata), exp_rd.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [3:0] a, input int e);
        cpu_rd   = 1'b1;
        cpu_addr = a;
        exp_rd.push_back(e);
        step(1);
        cpu_rd   = 1'b0;
    endtask

    task automatic ack_irq();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        @(negedge clk);
        check("irq_after_ack", int'(irq), 0);
        step(1);
    endtask

    task automatic pulse_tick(input bit want_irq);
        frame_tick = 1'b1;
        exp_sf.push_back(cyc + 1);
        if (want_irq) exp_irq.push_back(cyc + 19);
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_req(input bit want_irq);
        poll_req = 1'b1;
        exp_sf.push_back(cyc + 1);
        if (want_irq) exp_irq.push_back(cyc + 19);
        step(1);
        poll_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        frame_tick  = 1'b0;
        frame_tick2 = 1'b0;
        poll_req    = 1'b0;
        cpu_rd      = 1'b0;
        cpu_addr    = 4'd0;
        irq_ack     = 1'b0;
        buttons     = {8'h00, 8'h81};
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_start_fetch", int'(start_fetch), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_irq", int'(irq), 0);
        check("rst_rdata", int'(cpu_rdata), 0);
        step(1);

        // First poll from a frame tick.
        pulse_tick(1'b1);
        step(22);
        cpu_read(4'h0, 8'h81);
        cpu_read(4'h3, 8'h04);
        cpu_read(4'h4, 8'h00);
        cpu_read(4'hC, 8'h00);
        cpu_read(4'hF, 8'h04);
        @(negedge clk);
        check("irq_level", int'(irq), 1);
        check("busy_idle", int'(busy), 0);
        step(1);
        ack_irq();

        // Second poll by CPU request: release edge and read-clear of pressed.
        buttons = {8'h10, 8'h01};
        pulse_req(1'b1);
        step(22);
        ack_irq();
        cpu_read(4'h2, 8'h80);
        cpu_read(4'h1, 8'h81);
        cpu_read(4'h1, 8'h00);
        cpu_read(4'h5, 8'h10);
        cpu_read(4'h2, 8'h00);
        cpu_read(4'h6, 8'h00);
        cpu_read(4'h3, 8'h08);

        // Tick, then one queued request, then one overrun request.
        pulse_tick(1'b1);
        step(2);
        poll_req = 1'b1;
        exp_sf.push_back(cyc + 17);
        step(1);
        poll_req = 1'b0;
        step(1);
        poll_req = 1'b1;
        step(1);
        poll_req = 1'b0;
        step(16);
        irq_ack = 1'b1;
        exp_irq.push_back(cyc + 16);
        step(1);
        irq_ack = 1'b0;
        step(19);
        cpu_read(4'h3, 8'h12);
        cpu_read(4'h3, 8'h10);
        ack_irq();

        // Divide-by-3 instance: only ticks 3 and 6 poll.
        for (int i = 1; i <= 7; i++) begin
            frame_tick2 = 1'b1;
            if (i % 3 == 0) exp_sf2.push_back(cyc + 1);
            step(1);
            frame_tick2 = 1'b0;
            step(24);
        end
        @(negedge clk);
        check("div3_irq", int'(irq2), 1);
        check("div3_busy", int'(busy2), 0);
        check("div3_rdata", int'(cpu_rdata2), 0);
        step(1);

        // Read of pressed coinciding with a capture, and ack coinciding with capture.
        buttons = {8'h10, 8'h05};
        pulse_req(1'b1);
        step(22);
        buttons = {8'h10, 8'h07};
        pulse_req(1'b0);
        step(17);
        cpu_rd   = 1'b1;
        cpu_addr = 4'h1;
        irq_ack  = 1'b1;
        exp_rd.push_back(8'h04);
        step(1);
        cpu_rd   = 1'b0;
        irq_ack  = 1'b0;
        @(negedge clk);
        check("irq_ack_vs_capture", int'(irq), 1);
        step(1);
        cpu_read(4'h1, 8'h02);
        cpu_read(4'h3, 8'h18);
        ack_irq();

        // Reset during settle, then a normal poll.
        buttons = {8'h00, 8'h33};
        pulse_tick(1'b0);
        step(7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_start_fetch", int'(start_fetch), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_irq", int'(irq), 0);
        check("midrst_rdata", int'(cpu_rdata), 0);
        step(30);
        @(negedge clk);
        check("midrst_no_irq", int'(irq), 0);
        check("midrst_no_busy", int'(busy), 0);
        step(1);
        cpu_read(4'h3, 8'h00);
        cpu_read(4'h0, 8'h00);
        pulse_tick(1'b1);
        step(22);
        cpu_read(4'h0, 8'h33);
        cpu_read(4'h1, 8'h33);
        cpu_read(4'h3, 8'h04);
        step(5);

        check("sf_queue_drained", exp_sf.size(), 0);
        check("sf2_queue_drained", exp_sf2.size(), 0);
        check("irq_queue_drained", exp_irq.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
